// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 instruction-fetch front end.
// Contents: reset fetch PC, default queue geometry, and the entry
// type stored in the prefetch queue.
package mips32_pkg;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          QDEPTH_DEF   = 4;
  localparam int          MAX_OUT_DEF  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           empty the FIFO (wins over push/pop)
//   push, push_data write one entry
//   pop             retire the head entry
//   head            current head entry (storage read, no bypass)
//   count           number of valid entries
module fetch_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                do_push, do_pop;

  always_comb begin
    // A push into a full FIFO is only legal when the head leaves this cycle.
    do_push = push && ((count_q != CW'(DEPTH)) || pop);
    do_pop  = pop && (count_q != '0);
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_q] <= push_data;
  end

  assign head  = mem[rd_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with credit-based prefetch queue.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req/addr/ready         request channel to instruction memory
//   imem_rvalid/rdata           in-order response channel
//   redirect_valid/pc           PC redirect, flushes queue and in-flight work
//   if_valid/ir/pc/npc          head instruction presented to decode
//   id_ready                    decode accepts the head
//   q_count                     valid queue entries
module instr_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          QDEPTH   = QDEPTH_DEF,
  parameter int          MAX_OUT  = MAX_OUT_DEF,
  parameter logic [31:0] RESET_PC = mips32_pkg::RESET_PC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req,
  output logic [9:0]                imem_addr,
  input  logic                      imem_ready,
  input  logic                      imem_rvalid,
  input  logic [31:0]               imem_rdata,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      if_valid,
  output logic [31:0]               if_ir,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_npc,
  input  logic                      id_ready,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);
  localparam logic [CNT_W:0]   QDEPTH_V  = (CNT_W + 1)'(QDEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_q, discard_d;
  logic [TAG_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]      tag_mem [MAX_OUT];

  logic             credit_ok, issue, returned, push, pop;
  fetch_entry_t     push_entry, head;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // Queue entries plus in-flight requests never exceed the queue depth,
    // so every response that survives has a slot waiting for it.
    credit_ok = ({1'b0, q_count} + (CNT_W + 1)'(outstanding_q)) < QDEPTH_V;
    imem_req  = rst_n && !redirect_valid && (outstanding_q < MAX_OUT_V) && credit_ok;
    issue     = imem_req && imem_ready;
    // Responses with nothing in flight are protocol errors and ignored.
    returned  = imem_rvalid && (outstanding_q != '0);
    push      = returned && !redirect_valid && (discard_q == '0);
    pop       = if_valid && id_ready && !redirect_valid;

    outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(returned);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (issue)     fetch_pc_d = fetch_pc_q + 32'd1;

    tag_wr_d = issue ? tag_inc(tag_wr_q) : tag_wr_q;
    // On redirect every tag still queued belongs to a stale request.
    tag_rd_d = redirect_valid ? tag_wr_d : (push ? tag_inc(tag_rd_q) : tag_rd_q);

    // Everything still in flight after a redirect cycle is stale.
    discard_d = discard_q;
    if (redirect_valid)                       discard_d = outstanding_d;
    else if (returned && (discard_q != '0))   discard_d = discard_q - 1'b1;

    push_entry.pc = tag_mem[tag_rd_q];
    push_entry.ir = imem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_q] <= fetch_pc_q;
  end

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (q_count)
  );

  always_comb begin
    imem_addr = fetch_pc_q[9:0];
    if_valid  = (q_count != '0);
    // Head fields read as zero when the queue is empty (and so in reset).
    if_ir  = if_valid ? head.ir : 32'd0;
    if_pc  = if_valid ? head.pc : 32'd0;
    if_npc = if_valid ? (head.pc + 32'd1) : 32'd0;
  end

`ifndef SYNTHESIS
  rvalid_needs_inflight_a : assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding_q != '0));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  import mips32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_ir, if_pc, if_npc;
  logic        id_ready;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  instr_fetch_queue #(.QDEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .if_npc(if_npc),
    .id_ready(id_ready), .q_count(q_count)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  logic rdy_knob = 1'b1;
  logic idr_knob = 1'b1;
  logic [9:0] last_fire_addr = '0;

  typedef struct { logic [9:0] addr; int due; } pend_t;
  pend_t pend[$];

  typedef struct {
    logic        req;
    logic [9:0]  addr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses `lat` cycles after acceptance.
  task automatic begin_cycle();
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (!rst_n) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_ready = rdy_knob;
    id_ready   = idr_knob;
  endtask

  task automatic end_cycle();
    pend_t p;
    #1;
    if (!rst_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
    end else if (imem_req && imem_ready) begin
      p.addr = imem_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      last_fire_addr = imem_addr;
    end
  endtask

  task automatic cycle();
    begin_cycle();
    end_cycle();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    begin_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    end_cycle();
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (if_valid) begin ok = 1; break; end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_req(input string name, input logic [9:0] exp_addr);
    bit ok = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (imem_req && imem_ready) begin ok = 1; break; end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    else     check(name, {22'd0, imem_addr}, {22'd0, exp_addr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_addr;

    tbl[0] = '{1'b1, 10'd0, 1'b0, 32'd0, 3'd0};
    tbl[1] = '{1'b1, 10'd1, 1'b0, 32'd0, 3'd0};
    tbl[2] = '{1'b1, 10'd2, 1'b1, 32'd0, 3'd1};
    tbl[3] = '{1'b1, 10'd3, 1'b1, 32'd1, 3'd1};
    tbl[4] = '{1'b1, 10'd4, 1'b1, 32'd2, 3'd1};
    tbl[5] = '{1'b1, 10'd5, 1'b1, 32'd3, 3'd1};

    rst_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (3) cycle();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_vld",   {31'd0, if_valid}, 32'd0);
    check("rst_ir",    if_ir, 32'd0);
    check("rst_pc",    if_pc, 32'd0);
    check("rst_npc",   if_npc, 32'd0);
    check("rst_count", {29'd0, q_count}, 32'd0);

    // Streaming after reset release, 1-cycle memory.
    for (int i = 0; i < 6; i++) begin
      begin_cycle();
      if (i == 0) rst_n = 1'b1;
      end_cycle();
      check($sformatf("seq%0d_req", i),  {31'd0, imem_req}, {31'd0, tbl[i].req});
      check($sformatf("seq%0d_addr", i), {22'd0, imem_addr}, {22'd0, tbl[i].addr});
      check($sformatf("seq%0d_vld", i),  {31'd0, if_valid}, {31'd0, tbl[i].vld});
      check($sformatf("seq%0d_pc", i),   if_pc, tbl[i].pc);
      check($sformatf("seq%0d_npc", i),  if_npc, tbl[i].vld ? tbl[i].pc + 32'd1 : 32'd0);
      check($sformatf("seq%0d_ir", i),   if_ir, tbl[i].vld ? word(tbl[i].pc[9:0]) : 32'd0);
      check($sformatf("seq%0d_cnt", i),  {29'd0, q_count}, {29'd0, tbl[i].cnt});
    end

    // Decode stall: queue fills to depth and requests stop.
    idr_knob = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_cnt_le4", {31'd0, (q_count <= 3'd4)}, 32'd1);
      check("stall_pc", if_pc, 32'd4);
      check("stall_ir", if_ir, word(10'd4));
    end
    check("stall_full", {29'd0, q_count}, 32'd4);
    check("stall_noreq", {31'd0, imem_req}, 32'd0);
    idr_knob = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("drain_vld", {31'd0, if_valid}, 32'd1);
      check("drain_pc", if_pc, 32'd4 + i);
    end

    // Memory back-pressure: address held, fetch PC not advanced.
    exp_addr = last_fire_addr + 10'd1;
    rdy_knob = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_req", {31'd0, imem_req}, 32'd1);
      check("bp_addr", {22'd0, imem_addr}, {22'd0, exp_addr});
    end
    rdy_knob = 1'b1;
    cycle();
    check("bp_release_addr", {22'd0, imem_addr}, {22'd0, exp_addr});
    cycle();
    check("bp_next_addr", {22'd0, imem_addr}, {22'd0, exp_addr + 10'd1});

    // Redirect with two requests in flight and no response that cycle.
    lat = 3;
    begin
      bit found = 0;
      for (int i = 0; i < 30; i++) begin
        begin_cycle();
        if (pend.size() == 2 && !imem_rvalid) begin
          redirect_valid = 1'b1;
          redirect_pc    = 32'h40;
          found = 1;
        end
        end_cycle();
        if (found) break;
      end
      check("rd40_found", {31'd0, found}, 32'd1);
    end
    check("rd40_noreq", {31'd0, imem_req}, 32'd0);
    cycle();
    check("rd40_flush_vld", {31'd0, if_valid}, 32'd0);
    check("rd40_flush_cnt", {29'd0, q_count}, 32'd0);
    wait_req("rd40_first_addr", 10'h040);
    wait_valid("rd40_valid");
    check("rd40_pc", if_pc, 32'h40);
    check("rd40_ir", if_ir, word(10'h040));
    check("rd40_discard", {30'd0, dut.discard_q}, 32'd0);
    wait_valid("rd41_valid");
    check("rd41_pc", if_pc, 32'h41);

    // Back-to-back redirects: the second one wins.
    lat = 1;
    redirect_to(32'h80);
    redirect_to(32'h100);
    wait_req("b2b_first_addr", 10'h100);
    wait_valid("b2b_valid");
    check("b2b_pc", if_pc, 32'h100);
    check("b2b_ir", if_ir, word(10'h100));

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFF);
    wait_valid("wrap_valid0");
    check("wrap_pc0",  if_pc, 32'hFFFF_FFFF);
    check("wrap_npc0", if_npc, 32'h0);
    check("wrap_ir0",  if_ir, word(10'h3FF));
    wait_valid("wrap_valid1");
    check("wrap_pc1",  if_pc, 32'h0);
    check("wrap_npc1", if_npc, 32'h1);

    // Reset in the middle of traffic.
    lat = 3;
    idr_knob = 1'b0;
    begin
      bit found = 0;
      for (int i = 0; i < 30; i++) begin
        cycle();
        if (q_count >= 3'd2 && pend.size() >= 1) begin found = 1; break; end
      end
      check("mrst_found", {31'd0, found}, 32'd1);
    end
    begin_cycle();
    rst_n = 1'b0;
    #1;
    check("mrst_req",   {31'd0, imem_req}, 32'd0);
    check("mrst_vld",   {31'd0, if_valid}, 32'd0);
    check("mrst_ir",    if_ir, 32'd0);
    check("mrst_pc",    if_pc, 32'd0);
    check("mrst_npc",   if_npc, 32'd0);
    check("mrst_count", {29'd0, q_count}, 32'd0);
    check("mrst_out",   {30'd0, dut.outstanding_q}, 32'd0);
    end_cycle();
    lat = 1;
    idr_knob = 1'b1;
    begin_cycle();
    rst_n = 1'b1;
    end_cycle();
    check("mrst_restart_req",  {31'd0, imem_req}, 32'd1);
    check("mrst_restart_addr", {22'd0, imem_addr}, 32'd0);
    wait_valid("mrst_valid");
    check("mrst_first_pc", if_pc, 32'd0);
    check("mrst_first_ir", if_ir, word(10'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
